// File: rtl/my_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_mem_pkg
// Desc     : Shared types, constants and parity helper for the parity memory.
// Revision : 1.0 - initial release
// ============================================================================
package my_mem_pkg;

    localparam int ERR_CNT_W = 16;
    // Widest payload the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W = 64;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/my_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : my_mem_array
// Desc     : Single-port synchronous RAM, DATA_W+1 bits wide, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module my_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W:0]   i_wdata,
    output logic [DATA_W:0]   o_rdata
);

    logic [DATA_W:0] r_mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem_q[i_addr] <= i_wdata;
            end else begin
                r_rdata_q <= r_mem_q[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/my_mem_par.sv
`default_nettype none
// ============================================================================
// Module   : my_mem_par
// Desc     : Parity-protected RAM with power-up clear sweep and 1-cycle reads.
// Config   : MY_MEM_PARITY_CHECK_EN enables read-side parity check/err count.
// Revision : 1.0 - initial release
// ============================================================================
module my_mem_par
    import my_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic                 read,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 inj_par,
    output logic [DATA_W:0]      data_out,
    output logic                 rd_valid,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 init_done
);

    localparam logic [ADDR_W-1:0] c_sweep_last = {ADDR_W{1'b1}};

    state_e               r_state_q, w_state_d;
    logic [ADDR_W-1:0]    r_sweep_q, w_sweep_d;
    logic                 r_init_done_q, w_init_done_d;
    logic                 r_rd_pend_q, w_rd_pend_d;
    logic                 r_rd_valid_q, w_rd_valid_d;
    logic [DATA_W:0]      r_data_out_q, w_data_out_d;

    logic                 w_ram_en;
    logic                 w_ram_we;
    logic [ADDR_W-1:0]    w_ram_addr;
    logic [DATA_W:0]      w_ram_wdata;
    logic [DATA_W:0]      w_ram_rdata;
    logic [PAR_MAX_W-1:0] w_wr_ext;

    always_comb begin
        w_state_d     = r_state_q;
        w_sweep_d     = r_sweep_q;
        w_init_done_d = r_init_done_q;
        w_rd_pend_d   = 1'b0;
        w_rd_valid_d  = r_rd_pend_q;
        w_data_out_d  = r_rd_pend_q ? w_ram_rdata : r_data_out_q;
        w_ram_en      = 1'b0;
        w_ram_we      = 1'b0;
        w_ram_addr    = address;
        w_wr_ext      = '0;
        w_wr_ext[DATA_W-1:0] = data_in;
        w_ram_wdata   = {even_parity(w_wr_ext) ^ inj_par, data_in};

        case (r_state_q)
            CLEAR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_sweep_q;
                w_ram_wdata = '0;
                w_sweep_d   = r_sweep_q + 1'b1;
                if (r_sweep_q == c_sweep_last) begin
                    w_state_d     = READY;
                    w_init_done_d = 1'b1;
                end
            end
            READY: begin
                // Write wins a simultaneous read; the read is silently dropped.
                if (write) begin
                    w_ram_en = 1'b1;
                    w_ram_we = 1'b1;
                end else if (read) begin
                    w_ram_en    = 1'b1;
                    w_rd_pend_d = 1'b1;
                end
            end
            default: begin
                w_state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= CLEAR;
            r_sweep_q     <= '0;
            r_init_done_q <= 1'b0;
            r_rd_pend_q   <= 1'b0;
            r_rd_valid_q  <= 1'b0;
            r_data_out_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_sweep_q     <= w_sweep_d;
            r_init_done_q <= w_init_done_d;
            r_rd_pend_q   <= w_rd_pend_d;
            r_rd_valid_q  <= w_rd_valid_d;
            r_data_out_q  <= w_data_out_d;
        end
    end

    my_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

`ifdef MY_MEM_PARITY_CHECK_EN
    logic [PAR_MAX_W-1:0] w_rd_ext;
    logic                 w_par_mismatch;
    logic                 r_parity_err_q, w_parity_err_d;
    logic [ERR_CNT_W-1:0] r_err_count_q, w_err_count_d;

    always_comb begin
        w_rd_ext = '0;
        w_rd_ext[DATA_W-1:0] = w_ram_rdata[DATA_W-1:0];
        w_par_mismatch = even_parity(w_rd_ext) != w_ram_rdata[DATA_W];
        w_parity_err_d = r_rd_pend_q && w_par_mismatch;
        w_err_count_d  = r_err_count_q;
        if (w_parity_err_d && (r_err_count_q != {ERR_CNT_W{1'b1}})) begin
            w_err_count_d = r_err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err_q <= 1'b0;
            r_err_count_q  <= '0;
        end else begin
            r_parity_err_q <= w_parity_err_d;
            r_err_count_q  <= w_err_count_d;
        end
    end

    assign parity_err = r_parity_err_q;
    assign err_count  = r_err_count_q;
`else
    assign parity_err = 1'b0;
    assign err_count  = '0;
`endif

    assign data_out  = r_data_out_q;
    assign rd_valid  = r_rd_valid_q;
    assign init_done = r_init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_my_mem_par.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_mem_par
// Desc     : Directed self-checking bench for my_mem_par (DATA_W=8, ADDR_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_mem_par;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              inj_par = 1'b0;
    logic [DATA_W:0]   data_out;
    logic              rd_valid;
    logic              parity_err;
    logic [15:0]       err_count;
    logic              init_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] rnd_data [6];

    always #5 clk = ~clk;

    my_mem_par #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
        .inj_par    (inj_par),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .parity_err (parity_err),
        .err_count  (err_count),
        .init_done  (init_done)
    );

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic inj);
        @(negedge clk);
        write = 1'b1; address = a; data_in = d; inj_par = inj;
        @(negedge clk);
        write = 1'b0; inj_par = 1'b0;
    endtask

    // Leaves the bench #1 after the edge that presents the read result.
    task automatic do_read(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        read = 1'b1; address = a;
        @(negedge clk);
        read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        n_tests++; if (data_out !== 9'h000) begin n_fail++; $display("FAIL reset_data_out: got %h expected %h", data_out, 9'h000); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        n_tests++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err_count: got %h expected 0000", err_count); end
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        @(negedge clk);
        rst = 1'b0;
        // Address 0 is already swept at edge 10, so an accepted write would persist.
        for (int i = 1; i <= 16; i++) begin
            if (i == 10) begin write = 1'b1; address = 4'h0; data_in = 8'h55; end
            else if (i == 12) begin read = 1'b1; address = 4'h1; end
            @(posedge clk); #1;
            n_tests++;
            if (init_done !== (i == 16)) begin n_fail++; $display("FAIL sweep_init_done[%0d]: got %b expected %b", i, init_done, (i == 16)); end
            n_tests++;
            if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_rd_valid[%0d]: got %b expected 0", i, rd_valid); end
            @(negedge clk);
            write = 1'b0; read = 1'b0;
        end
    endtask

    task automatic test_init_read;
        for (int a = 0; a < 16; a++) begin
            do_read(a[ADDR_W-1:0]);
            n_tests++;
            if (data_out !== 9'h000 || rd_valid !== 1'b1 || parity_err !== 1'b0) begin
                n_fail++;
                $display("FAIL init_read[%0d]: got data=%h valid=%b perr=%b expected data=000 valid=1 perr=0", a, data_out, rd_valid, parity_err);
            end
        end
    endtask

    task automatic test_write_read;
        do_write(4'h3, 8'hA5, 1'b0);
        do_read(4'h3);
        n_tests++;
        if (data_out !== 9'h0A5 || rd_valid !== 1'b1 || parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_read: got data=%h valid=%b perr=%b expected data=0a5 valid=1 perr=0", data_out, rd_valid, parity_err);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rd_valid !== 1'b0 || data_out !== 9'h0A5) begin
            n_fail++;
            $display("FAIL hold_after_read: got data=%h valid=%b expected data=0a5 valid=0", data_out, rd_valid);
        end
    endtask

    task automatic test_inj_par;
        logic       exp_perr;
        logic [15:0] exp_cnt;
`ifdef MY_MEM_PARITY_CHECK_EN
        exp_perr = 1'b1; exp_cnt = 16'd1;
`else
        exp_perr = 1'b0; exp_cnt = 16'd0;
`endif
        do_write(4'h9, 8'h07, 1'b1);
        do_read(4'h9);
        n_tests++;
        if (data_out !== 9'h007 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inj_par_data: got data=%h valid=%b expected data=007 valid=1", data_out, rd_valid);
        end
        n_tests++;
        if (parity_err !== exp_perr) begin n_fail++; $display("FAIL inj_par_perr: got %b expected %b", parity_err, exp_perr); end
        @(posedge clk); #1;
        n_tests++;
        if (err_count !== exp_cnt) begin n_fail++; $display("FAIL inj_par_count: got %0d expected %0d", err_count, exp_cnt); end
    endtask

    task automatic test_collision;
        @(negedge clk);
        write = 1'b1; read = 1'b1; address = 4'h2; data_in = 8'h3C;
        @(posedge clk); #1;
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL collision_valid0: got %b expected 0", rd_valid); end
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL collision_valid1: got %b expected 0", rd_valid); end
        do_read(4'h2);
        n_tests++;
        if (data_out !== 9'h03C || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_read: got data=%h valid=%b expected data=03c valid=1", data_out, rd_valid);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        read = 1'b1; address = 4'h3;
        @(negedge clk);
        read = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (rd_valid !== 1'b0 || data_out !== 9'h000 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: got valid=%b data=%h init=%b expected valid=0 data=000 init=0", rd_valid, data_out, init_done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) begin write = 1'b1; address = 4'hF; data_in = 8'hFF; end
            @(posedge clk); #1;
            @(negedge clk);
            write = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (init_done !== (i == 16)) begin n_fail++; $display("FAIL restart_init_done[%0d]: got %b expected %b", i, init_done, (i == 16)); end
            @(negedge clk);
        end
        do_read(4'hF);
        n_tests++;
        if (data_out !== 9'h000) begin n_fail++; $display("FAIL restart_clear_f: got %h expected 000", data_out); end
    endtask

    task automatic test_random_pairs;
        logic [DATA_W:0] exp;
        for (int i = 0; i < 6; i++) begin
            rnd_data[i] = DATA_W'($urandom_range(0, 255));
            do_write(i[ADDR_W-1:0], rnd_data[i], 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            exp = {^rnd_data[i], rnd_data[i]};
            do_read(i[ADDR_W-1:0]);
            n_tests++;
            if (data_out !== exp || rd_valid !== 1'b1 || parity_err !== 1'b0) begin
                n_fail++;
                $display("FAIL random_read[%0d]: got data=%h valid=%b perr=%b expected data=%h valid=1 perr=0", i, data_out, rd_valid, parity_err, exp);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (err_count !== 16'h0) begin n_fail++; $display("FAIL random_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_back_to_back;
        logic [DATA_W:0] exp;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin read = 1'b1; address = i[ADDR_W-1:0]; end
            else read = 1'b0;
            @(posedge clk); #1;
            if (i > 0) begin
                exp = {^rnd_data[i-1], rnd_data[i-1]};
                n_tests++;
                if (data_out !== exp || rd_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_read[%0d]: got data=%h valid=%b expected data=%h valid=1", i - 1, data_out, rd_valid, exp);
                end
            end
        end
        @(posedge clk); #1;
        exp = {^rnd_data[3], rnd_data[3]};
        n_tests++;
        if (rd_valid !== 1'b0 || data_out !== exp) begin
            n_fail++;
            $display("FAIL b2b_hold: got data=%h valid=%b expected data=%h valid=0", data_out, rd_valid, exp);
        end
        // Read issued on the cycle right after a write to the same address.
        @(negedge clk);
        write = 1'b1; address = 4'h7; data_in = 8'h83;
        @(negedge clk);
        write = 1'b0; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (data_out !== 9'h183 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_read: got data=%h valid=%b expected data=183 valid=1", data_out, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_write_read();
        test_inj_par();
        test_collision();
        test_reset_mid();
        test_random_pairs();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/my_mem_par.md
MY_MEM_PAR -- requirements
Module: my_mem_par

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 8, SHALL set the data payload width in bits.
REQ-003 Parameter ADDR_W, default 16, SHALL set the address width; depth SHALL be 2**ADDR_W words of DATA_W+1 bits.
REQ-004 Port clk, input, 1, SHALL be the single rising-edge clock.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port write, input, 1, SHALL be the write strobe, sampled at rising clk.
REQ-007 Port read, input, 1, SHALL be the read strobe, sampled at rising clk.
REQ-008 Port address, input, ADDR_W, SHALL be the word address for read or write.
REQ-009 Port data_in, input, DATA_W, SHALL be the write payload.
REQ-010 Port inj_par, input, 1, SHALL invert the stored parity bit when high with an accepted write.
REQ-011 Port data_out, output, DATA_W+1, SHALL be {parity, data} of the last accepted read.
REQ-012 Port rd_valid, output, 1, SHALL pulse for one cycle when data_out is updated.
REQ-013 Port parity_err, output, 1, SHALL flag a parity mismatch on the data_out word, qualified by rd_valid.
REQ-014 Port err_count, output, 16, SHALL count parity errors detected since reset.
REQ-015 Port init_done, output, 1, SHALL be high when the clear sweep is complete and commands are accepted.

Function
REQ-016 The FSM SHALL have states CLEAR and READY; reset SHALL enter CLEAR with the sweep pointer at 0.
REQ-017 In CLEAR, the block SHALL write all-zero data with parity 0 to one address per cycle, 0 upward; after address 2**ADDR_W-1 it SHALL enter READY.
REQ-018 Write and read SHALL be ignored in CLEAR: no storage change, no rd_valid.
REQ-019 Stored parity SHALL be even, the XOR of all data_in bits, stored in bit DATA_W and inverted when inj_par is high.
REQ-020 An accepted write in READY SHALL update storage at the clock edge where write is sampled.
REQ-021 An accepted read SHALL have latency 1: data_out and rd_valid are updated at the edge after the one where read is sampled.
REQ-022 When write and read are both high, the write SHALL execute, the read SHALL be dropped, and rd_valid SHALL stay 0.
REQ-023 A read SHALL follow a write to the same address on the previous cycle and return the new word (read-after-write).
REQ-024 data_out SHALL hold its value between reads; rd_valid SHALL be 0 in every cycle without a new read result.
REQ-025 err_count SHALL increment once per rd_valid with parity_err high and saturate at 16'hFFFF.
REQ-026 Back-to-back reads SHALL be accepted every cycle, with one rd_valid per read.

Reset
REQ-027 Reset SHALL drive data_out=0, rd_valid=0, parity_err=0, err_count=0, init_done=0 on the next edge.
REQ-028 Reset asserted mid-sweep or mid-read SHALL cancel any pending read result and restart the sweep from address 0.

Configuration
REQ-029 With MY_MEM_PARITY_CHECK_EN defined, the block SHALL recompute parity on read and drive parity_err and err_count as specified.
REQ-030 Without MY_MEM_PARITY_CHECK_EN, parity_err and err_count SHALL be tied to 0 with no check logic; parity SHALL still be stored and returned in data_out[DATA_W].

Structure
REQ-031 Package my_mem_pkg SHALL hold the state enum typedef, the ERR_CNT_W=16 constant and the even-parity function.
REQ-032 The storage array SHALL be the sub-module my_mem_array, a single-port synchronous RAM of width DATA_W+1.

Verification (DATA_W=8, ADDR_W=4)
REQ-033 Reset, then idle -> init_done rises 16 cycles after rst falls; reading addresses 0..15 returns 9'h000 with parity_err=0.
REQ-034 Write 8'hA5 to 4'h3, then read 4'h3 -> one cycle later data_out=9'h0A5, rd_valid=1, parity_err=0.
REQ-035 Write 8'h07 to 4'h9 with inj_par=1, then read -> data_out=9'h007, parity_err=1, err_count=1.
REQ-036 write=1 and read=1 together at 4'h2 with data 8'h3C -> no rd_valid; a later read of 4'h2 returns 9'h03C.
REQ-037 Write issued during CLEAR, then reset pulse mid-sweep -> storage unchanged, sweep restarts, init_done=0 until 16 cycles after the reset pulse.
REQ-038 Six random write/read pairs (written at 4'h0..4'h5, then read back) -> every read returns the written data with correct even parity and err_count=0.
